dmem_lsu: RTL and testbench

//  Parametrised data memory with a load/store unit for the RISC-V pipeline MEM stage; replaces the single-cycle 32-bit data memory.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_bank.sv | 25 ++
 rtl/dmem_lsu.sv | 122 ++++++++++++
 tb/tb_dmem_lsu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared funct3 encodings, FSM state type and access-size helpers for dmem_lsu.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {IDLE, RESP} state_t;

  function automatic int unsigned size_bytes(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic logic is_legal(input logic [2:0] f3, input int unsigned data_w);
    if (f3 == 3'b111)
      return 1'b0;
    if (f3 == F3_D || f3 == F3_WU)
      return data_w == 64;
    return 1'b1;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x DATA_W synchronous-read RAM with per-byte write enables; contents are not reset.
module dmem_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128
) (
  input  logic                       clk,
  input  logic                       re,
  input  logic [DATA_W/8-1:0]        we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re)
      rdata <= mem[addr];
    for (int unsigned b = 0; b < DATA_W/8; b++) begin
      if (we[b])
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data memory load/store unit: valid/ready request, one-cycle registered response.
// Build option DMEM_MISALIGN_TRAP_EN: fault misaligned accesses instead of aligning them down.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 128,
  localparam int unsigned OFF_W  = $clog2(DATA_W/8),
  localparam int unsigned ADDR_W = $clog2(DEPTH) + OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault
);

  localparam int unsigned NB = DATA_W / 8;

  state_t            state, state_nx;
  logic              accept, legal, fault;
  logic [OFF_W-1:0]  off, size_m1, eff_off;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wlanes, bank_rdata, shifted, keep;
  logic              sgn;
  logic              r_load, r_fault;
  logic [2:0]        r_f3;
  logic [OFF_W-1:0]  r_off;

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept)
          state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept  = req_valid & req_ready & (req_re | req_we) & ~reset;
    legal   = is_legal(req_funct3, DATA_W);
    off     = req_addr[OFF_W-1:0];
    size_m1 = OFF_W'(size_bytes(req_funct3) - 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    fault   = ~legal | ((off & size_m1) != '0);
    eff_off = off;
`else
    fault   = ~legal;
    eff_off = off & ~size_m1;
`endif
    // Aligned lanes: the source byte for lane b is b modulo the access size.
    be     = '0;
    wlanes = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      be[b] = accept & ~req_re & ~fault &
              (b >= 32'(eff_off)) & (b <= 32'(eff_off) + 32'(size_m1));
      wlanes[8*b +: 8] = req_wdata[8*(b & 32'(size_m1)) +: 8];
    end
  end

  dmem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk   (clk),
    .re    (accept & req_re),
    .we    (be),
    .addr  (req_addr[ADDR_W-1:OFF_W]),
    .wdata (wlanes),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      r_load  <= 1'b0;
      r_fault <= 1'b0;
      r_f3    <= '0;
      r_off   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        r_load  <= req_re;
        r_fault <= fault;
        r_f3    <= req_funct3;
        r_off   <= eff_off;
      end
    end
  end

  always_comb begin
    shifted = bank_rdata >> {r_off, 3'b000};
    case (r_f3[1:0])
      2'b00:   begin keep = DATA_W'(8'hFF);          sgn = shifted[7];        end
      2'b01:   begin keep = DATA_W'(16'hFFFF);       sgn = shifted[15];       end
      2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF);  sgn = shifted[31];       end
      default: begin keep = '1;                      sgn = shifted[DATA_W-1]; end
    endcase
    sgn        = sgn & ~r_f3[2];
    resp_rdata = '0;
    if (resp_valid && r_load && !r_fault)
      resp_rdata = (shifted & keep) | ({DATA_W{sgn}} & ~keep);
    resp_fault = resp_valid & r_fault;
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu (DATA_W=32, DEPTH=128): directed table, corner sequences, random vs byte-array model.
module tb_dmem_lsu;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEP   = 128;
  localparam int unsigned AW    = 9;
  localparam int unsigned NBYTE = DEP * DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_re, req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_fault;
  logic [DW-1:0] resp_rdata;

  int total = 0;
  int bad   = 0;
  logic [7:0] mbytes [NBYTE];

  always #5 clk = ~clk;

  dmem_lsu #(
    .DATA_W (DW),
    .DEPTH  (DEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_re     (req_re),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // Byte-addressed reference: little-endian memory, alignment and legality from the access rules.
  function automatic void model(input logic re, input logic we, input logic [2:0] f3,
                                input logic [AW-1:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic f);
    int unsigned sz = 1 << f3[1:0];
    int unsigned a  = addr;
    bit legal = !(f3 == 3'd7 || (DW == 32 && (f3 == 3'd3 || f3 == 3'd6)));
    bit mis   = (a % sz) != 0;
    longint unsigned v = 0;
    rd = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    f = !legal || mis;
`else
    f = !legal;
    a = a - (a % sz);
`endif
    if (f) return;
    if (re) begin
      for (int unsigned i = 0; i < sz; i++)
        v |= longint'(mbytes[a+i]) << (8*i);
      if (!f3[2] && sz < 4 && v[8*sz-1])
        v |= ~((64'd1 << (8*sz)) - 1);
      rd = v[31:0];
    end else if (we) begin
      for (int unsigned i = 0; i < sz; i++)
        mbytes[a+i] = 8'(wd >> (8*i));
    end
  endfunction

  task automatic xact(input logic re, input logic we, input logic [2:0] f3,
                      input logic [AW-1:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_f, input string nm);
    @(negedge clk);
    req_valid = 1'b1; req_re = re; req_we = we;
    req_funct3 = f3; req_addr = addr; req_wdata = wd;
    chk({nm, ".ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({nm, ".valid"}, 32'(resp_valid), 32'd1);
    chk({nm, ".ready_resp"}, 32'(req_ready), 32'd0);
    chk({nm, ".rdata"}, resp_rdata, exp_rd);
    chk({nm, ".fault"}, 32'(resp_fault), 32'(exp_f));
    @(posedge clk); #1;
    chk({nm, ".valid_drop"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic mxact(input logic re, input logic we, input logic [2:0] f3,
                       input logic [AW-1:0] addr, input logic [31:0] wd, input string nm);
    logic [31:0] rd;
    logic f;
    model(re, we, f3, addr, wd, rd, f);
    xact(re, we, f3, addr, wd, rd, f, nm);
  endtask

  typedef struct {
    logic          re, we;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [31:0]   wd, rd;
    logic          f;
    string         nm;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] drd;
    logic        dfl;

    tbl[0]  = '{1'b0, 1'b1, 3'd2, 9'h10, 32'hDEADBEEF, 32'h0,        1'b0, "sw10"};
    tbl[1]  = '{1'b1, 1'b0, 3'd2, 9'h10, 32'h0,        32'hDEADBEEF, 1'b0, "lw10a"};
    tbl[2]  = '{1'b0, 1'b1, 3'd0, 9'h11, 32'h00000080, 32'h0,        1'b0, "sb11"};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 9'h11, 32'h0,        32'hFFFFFF80, 1'b0, "lb11"};
    tbl[4]  = '{1'b1, 1'b0, 3'd4, 9'h11, 32'h0,        32'h00000080, 1'b0, "lbu11"};
    tbl[5]  = '{1'b1, 1'b0, 3'd2, 9'h10, 32'h0,        32'hDEAD80EF, 1'b0, "lw10b"};
    tbl[6]  = '{1'b0, 1'b1, 3'd1, 9'h12, 32'h00001234, 32'h0,        1'b0, "sh12"};
    tbl[7]  = '{1'b1, 1'b0, 3'd1, 9'h12, 32'h0,        32'h00001234, 1'b0, "lh12"};
    tbl[8]  = '{1'b1, 1'b0, 3'd5, 9'h12, 32'h0,        32'h00001234, 1'b0, "lhu12"};
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl[9]  = '{1'b1, 1'b0, 3'd2, 9'h13, 32'h0,        32'h0,        1'b1, "lw13"};
`else
    tbl[9]  = '{1'b1, 1'b0, 3'd2, 9'h13, 32'h0,        32'h123480EF, 1'b0, "lw13"};
`endif
    tbl[10] = '{1'b1, 1'b1, 3'd2, 9'h10, 32'h0,        32'h123480EF, 1'b0, "rewe10"};
    tbl[11] = '{1'b1, 1'b0, 3'd2, 9'h10, 32'h0,        32'h123480EF, 1'b0, "lw10c"};
    tbl[12] = '{1'b0, 1'b1, 3'd7, 9'h10, 32'h0,        32'h0,        1'b1, "f3_111"};
    tbl[13] = '{1'b1, 1'b0, 3'd2, 9'h10, 32'h0,        32'h123480EF, 1'b0, "lw10d"};
    tbl[14] = '{1'b1, 1'b0, 3'd3, 9'h10, 32'h0,        32'h0,        1'b1, "ld_rv32"};

    reset = 1'b1; req_valid = 1'b0; req_re = 1'b0; req_we = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(resp_valid), 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.fault", 32'(resp_fault), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int unsigned w = 0; w < DEP; w++)
      mxact(1'b0, 1'b1, 3'd2, AW'(w * 4), $urandom, "init");

    for (int i = 0; i < 15; i++) begin
      model(tbl[i].re, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, drd, dfl);
      xact(tbl[i].re, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].f, tbl[i].nm);
    end

    // A request with neither re nor we produces nothing.
    @(negedge clk);
    req_valid = 1'b1; req_re = 1'b0; req_we = 1'b1; req_we = 1'b0; req_addr = 9'h10;
    @(posedge clk); #1;
    chk("noop.valid", 32'(resp_valid), 32'd0);
    chk("noop.ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;

    // Reset during RESP: response drops, the committed store remains.
    @(negedge clk);
    req_valid = 1'b1; req_re = 1'b0; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 9'h20; req_wdata = 32'hCAFEF00D;
    model(1'b0, 1'b1, 3'd2, 9'h20, 32'hCAFEF00D, drd, dfl);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstresp.valid_before", 32'(resp_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstresp.valid", 32'(resp_valid), 32'd0);
    chk("rstresp.ready", 32'(req_ready), 32'd1);
    chk("rstresp.rdata", resp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    xact(1'b1, 1'b0, 3'd2, 9'h20, 32'h0, 32'hCAFEF00D, 1'b0, "rstresp.lw20");

    for (int i = 0; i < 400; i++) begin
      logic [1:0] op = 2'($urandom_range(1, 3));
      mxact(op[1], op[0], 3'($urandom_range(0, 7)), AW'($urandom), $urandom, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
